// File: rtl/ysyx_22050710_arb_pkg.sv
// ysyx_22050710_arb_pkg
// Shared types for the IFU/LSU memory arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, REQ, RSP, TMO)
//   arb_owner_e : which requester owns the in-flight transaction
package ysyx_22050710_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    TMO  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22050710_arb_pick.sv
// ysyx_22050710_arb_pick
// Combinational grant selection between IFU and LSU.
//   i_if_valid / i_ls_valid : raw request valids
//   i_last_grant            : previous winner (YSYX_22050710_ARB_RR_EN only)
//   o_grant_if / o_grant_ls : one-hot grant (both 0 when nobody asks)
// Macro YSYX_22050710_ARB_RR_EN selects round-robin on conflict; without it
// the LSU always wins a conflict.
module ysyx_22050710_arb_pick
  import ysyx_22050710_arb_pkg::*;
(
  input  logic       i_if_valid,
  input  logic       i_ls_valid,
`ifdef YSYX_22050710_ARB_RR_EN
  input  arb_owner_e i_last_grant,
`endif
  output logic       o_grant_if,
  output logic       o_grant_ls
);

  always_comb begin
    o_grant_if = 1'b0;
    o_grant_ls = 1'b0;
    if (i_if_valid && i_ls_valid) begin
`ifdef YSYX_22050710_ARB_RR_EN
      // Hand the conflict to whoever did not win last time.
      if (i_last_grant == OWN_IF) o_grant_ls = 1'b1;
      else                        o_grant_if = 1'b1;
`else
      // LSU first: it belongs to the older instruction.
      o_grant_ls = 1'b1;
`endif
    end else begin
      o_grant_if = i_if_valid;
      o_grant_ls = i_ls_valid;
    end
  end

endmodule

// File: rtl/ysyx_22050710_mem_arbiter.sv
// ysyx_22050710_mem_arbiter
// Shares one memory port between IFU and LSU, one transaction in flight.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_if_* / o_if_*         : IFU request (addr) and response (rdata)
//   i_ls_* / o_ls_*         : LSU request (addr/wen/wdata/wmask) and response
//   o_mem_* / i_mem_*       : memory request (latched fields) and response
//   o_busy                  : FSM not in IDLE
//   o_timeout               : sticky watchdog error
// Optional macro YSYX_22050710_ARB_RR_EN: round-robin on conflicting requests.
// Watchdog: the counter value after the Nth cycle spent in REQ/RSP is N; when
// it reaches TIMEOUT_CYCLES without a response handshake the FSM moves to TMO
// and answers the owner with rdata=0. TIMEOUT_CYCLES=0 disables it.
module ysyx_22050710_mem_arbiter
  import ysyx_22050710_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req_valid,
  output logic                o_if_req_ready,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_rsp_valid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_if_rsp_ready,
  input  logic                i_ls_req_valid,
  output logic                o_ls_req_ready,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic                i_ls_wen,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_wmask,
  output logic                o_ls_rsp_valid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  input  logic                i_ls_rsp_ready,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_rsp_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_mem_rsp_ready,
  output logic                o_busy,
  output logic                o_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_e          r_state;
  arb_owner_e          r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_timeout;
`ifdef YSYX_22050710_ARB_RR_EN
  arb_owner_e          r_last;
`endif

  logic              w_pick_if, w_pick_ls;
  logic              w_idle, w_gnt_if, w_gnt_ls;
  logic              w_own_rsp_ready, w_own_rsp_valid, w_rsp_hs;
  logic [DATA_W-1:0] w_rdata;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_tmo_hit;

  ysyx_22050710_arb_pick u_pick (
    .i_if_valid   (i_if_req_valid),
    .i_ls_valid   (i_ls_req_valid),
`ifdef YSYX_22050710_ARB_RR_EN
    .i_last_grant (r_last),
`endif
    .o_grant_if   (w_pick_if),
    .o_grant_ls   (w_pick_ls)
  );

  assign w_idle   = (r_state == IDLE);
  assign w_gnt_if = w_idle & w_pick_if;
  assign w_gnt_ls = w_idle & w_pick_ls;

  assign w_own_rsp_ready = (r_owner == OWN_LS) ? i_ls_rsp_ready : i_if_rsp_ready;
  // TMO fabricates a response; RSP passes memory straight through.
  assign w_own_rsp_valid = ((r_state == RSP) & i_mem_rsp_valid) | (r_state == TMO);
  assign w_rdata         = (r_state == RSP) ? i_mem_rdata : '0;
  assign w_rsp_hs        = (r_state == RSP) & i_mem_rsp_valid & w_own_rsp_ready;

  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_owner   <= OWN_IF;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`ifdef YSYX_22050710_ARB_RR_EN
      r_last    <= OWN_LS;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_if || w_gnt_ls) begin
            r_state <= REQ;
            r_cnt   <= '0;
            if (w_gnt_ls) begin
              r_owner <= OWN_LS;
              r_addr  <= i_ls_addr;
              r_wen   <= i_ls_wen;
              r_wdata <= i_ls_wdata;
              r_wmask <= i_ls_wmask;
            end else begin
              r_owner <= OWN_IF;
              r_addr  <= i_if_addr;
              r_wen   <= 1'b0;
              r_wdata <= '0;
              r_wmask <= '0;
            end
`ifdef YSYX_22050710_ARB_RR_EN
            r_last <= w_gnt_ls ? OWN_LS : OWN_IF;
`endif
          end
        end
        REQ: begin
          r_cnt <= w_cnt_nxt;
          if (w_tmo_hit) begin
            r_state   <= TMO;
            r_timeout <= 1'b1;
          end else if (i_mem_req_ready) begin
            r_state <= RSP;
          end
        end
        RSP: begin
          r_cnt <= w_cnt_nxt;
          // A response handshake in the timeout cycle still completes normally.
          if (w_rsp_hs) begin
            r_state <= IDLE;
          end else if (w_tmo_hit) begin
            r_state   <= TMO;
            r_timeout <= 1'b1;
          end
        end
        TMO: begin
          if (w_own_rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_if_req_ready  = w_gnt_if;
  assign o_ls_req_ready  = w_gnt_ls;
  assign o_mem_req_valid = (r_state == REQ);
  assign o_mem_addr      = r_addr;
  assign o_mem_wen       = r_wen;
  assign o_mem_wdata     = r_wdata;
  assign o_mem_wmask     = r_wmask;
  assign o_mem_rsp_ready = (r_state == RSP) & w_own_rsp_ready;
  assign o_if_rsp_valid  = (r_owner == OWN_IF) & w_own_rsp_valid;
  assign o_ls_rsp_valid  = (r_owner == OWN_LS) & w_own_rsp_valid;
  assign o_if_rdata      = (r_owner == OWN_IF) ? w_rdata : '0;
  assign o_ls_rdata      = (r_owner == OWN_LS) ? w_rdata : '0;
  assign o_busy          = ~w_idle;
  assign o_timeout       = r_timeout;

endmodule
